mp_reg_file: RTL and testbench

//  Parametrised multi-port integer register file for the next rvcpu core.

---
 rtl/mp_reg_file_pkg.sv | 10 +
 rtl/mp_reg_file_scoreboard.sv | 101 ++++++++++
 rtl/mp_reg_file.sv | 110 +++++++++++
 tb/tb_mp_reg_file.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_reg_file_pkg.sv
// Shared register-file constants for the rvcpu integer datapath.
package mp_reg_file_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = $clog2(NREGS);

    localparam logic [REG_AW-1:0] X0_ADDR = '0;

endpackage

// File: rtl/mp_reg_file_scoreboard.sv
// Per-register pending-write counters: alloc stall, busy view, operand ready.
module mp_reg_file_scoreboard #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NRD-1:0]    ren,
    input  logic [NRD*AW-1:0] raddr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              flush,
    output logic              alloc_stall,
    output logic [NREGS-1:0]  busy_vec,
    output logic [NRD-1:0]    rready
);
    import mp_reg_file_pkg::*;

    localparam int unsigned HW = $clog2(NWR + 1);
    localparam int unsigned SW = ((CNT_W > HW) ? CNT_W : HW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [NREGS];
    logic [CNT_W-1:0] cnt_nxt [NREGS];
    logic [HW-1:0]    hits    [NREGS];
    logic             inc;
    logic [SW-1:0]    sum;
    logic [AW-1:0]    ra;

    // Count how many write ports land on each register this cycle
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            hits[r] = '0;
            for (int unsigned k = 0; k < NWR; k++) begin
                if (wen[k] && (waddr[k*AW +: AW] == AW'(r))) begin
                    hits[r] = hits[r] + HW'(1);
                end
            end
        end
    end

    // A saturated counter cannot accept another alloc; x0 never stalls
    assign alloc_stall = alloc_en && (alloc_addr != AW'(X0_ADDR)) && (cnt[alloc_addr] == CNT_MAX);

    // Next counter value: +alloc, -writebacks, floored at zero, flush clears
    always_comb begin
        inc = 1'b0;
        sum = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_nxt[r] = '0;
        end
        for (int unsigned r = 1; r < NREGS; r++) begin
            inc = alloc_en && !alloc_stall && (alloc_addr == AW'(r));
            sum = SW'(cnt[r]) + SW'(inc);
            if (flush) begin
                cnt_nxt[r] = '0;
            end else if (sum > SW'(hits[r])) begin
                cnt_nxt[r] = CNT_W'(sum - SW'(hits[r]));
            end else begin
                cnt_nxt[r] = '0;
            end
        end
    end

    // Counter state with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
        end
    end

    // Busy view of the counters
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    // Operand ready: nothing pending, or every pending write lands this cycle
    always_comb begin
        rready = '0;
        ra     = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            ra = raddr[j*AW +: AW];
            if (!ren[j] || (ra == AW'(X0_ADDR)) || (cnt[ra] == '0)) begin
                rready[j] = 1'b1;
            end else if ((BYPASS != 0) && (SW'(cnt[ra]) <= SW'(hits[ra]))) begin
                rready[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port integer register file with writeback bypass and pending-write scoreboard.
module mp_reg_file #(
    parameter int unsigned XLEN   = mp_reg_file_pkg::XLEN,
    parameter int unsigned NREGS  = mp_reg_file_pkg::NREGS,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    input  logic [NRD-1:0]      i_ren,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    output logic [NRD-1:0]      o_rready,
    input  logic                i_alloc_en,
    input  logic [AW-1:0]       i_alloc_addr,
    output logic                o_alloc_stall,
    input  logic                i_flush,
    output logic [NREGS-1:0]    o_busy_vec
);
    import mp_reg_file_pkg::*;

    logic [XLEN-1:0]  regs    [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_data [NREGS];
    logic [AW-1:0]    waddr_a [NWR];
    logic [XLEN-1:0]  wdata_a [NWR];
    logic [AW-1:0]    raddr_a [NRD];

    // Unpack flat port buses
    generate
        for (genvar k = 0; k < NWR; k++) begin : g_wr
            assign waddr_a[k] = i_waddr[k*AW +: AW];
            assign wdata_a[k] = i_wdata[k*XLEN +: XLEN];
        end
        for (genvar j = 0; j < NRD; j++) begin : g_rd
            assign raddr_a[j] = i_raddr[j*AW +: AW];
        end
    endgenerate

    // Write arbitration: the youngest (highest) port wins; x0 is never written
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            wr_hit[r]  = 1'b0;
            wr_data[r] = '0;
            for (int unsigned k = 0; k < NWR; k++) begin
                if (i_wen[k] && (waddr_a[k] == AW'(r)) && (waddr_a[k] != AW'(X0_ADDR))) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = wdata_a[k];
                end
            end
        end
    end

    // Data array with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) regs[r] <= wr_data[r];
            end
        end
    end

    // Read muxes with optional same-cycle forwarding of the youngest write
    always_comb begin
        o_rdata = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            if (i_ren[j] && (raddr_a[j] != AW'(X0_ADDR))) begin
                o_rdata[j*XLEN +: XLEN] = regs[raddr_a[j]];
                if (BYPASS != 0) begin
                    for (int unsigned k = 0; k < NWR; k++) begin
                        if (i_wen[k] && (waddr_a[k] == raddr_a[j])) begin
                            o_rdata[j*XLEN +: XLEN] = wdata_a[k];
                        end
                    end
                end
            end
        end
    end

    // Pending-write scoreboard
    mp_reg_file_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .CNT_W  (CNT_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wen         (i_wen),
        .waddr       (i_waddr),
        .ren         (i_ren),
        .raddr       (i_raddr),
        .alloc_en    (i_alloc_en),
        .alloc_addr  (i_alloc_addr),
        .flush       (i_flush),
        .alloc_stall (o_alloc_stall),
        .busy_vec    (o_busy_vec),
        .rready      (o_rready)
    );

endmodule

// File: tb/tb_mp_reg_file.sv
// Directed bench for mp_reg_file: vector table plus reset, bypass and flush sequences.
module tb_mp_reg_file;

    logic         clk;
    logic         rst_n;
    logic [1:0]   wen;
    logic [9:0]   waddr;
    logic [127:0] wdata;
    logic [1:0]   ren;
    logic [9:0]   raddr;
    logic         alloc_en;
    logic [4:0]   alloc_addr;
    logic         flush;

    logic [127:0] rdata;
    logic [1:0]   rready;
    logic         stall;
    logic [31:0]  busy;
    logic [127:0] rdata_nb;
    logic [1:0]   rready_nb;
    logic         stall_nb;
    logic [31:0]  busy_nb;

    int checks   = 0;
    int failures = 0;

    mp_reg_file #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_ren(ren), .i_raddr(raddr), .o_rdata(rdata), .o_rready(rready),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_alloc_stall(stall),
        .i_flush(flush), .o_busy_vec(busy)
    );

    mp_reg_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_ren(ren), .i_raddr(raddr), .o_rdata(rdata_nb), .o_rready(rready_nb),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_alloc_stall(stall_nb),
        .i_flush(flush), .o_busy_vec(busy_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [63:0] wd0;
        logic [63:0] wd1;
        logic        alloc_en;
        logic [4:0]  alloc_addr;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] rd0;
        logic [63:0] rd1;
        logic [1:0]  rready;
        logic        stall;
        logic [31:0] busy;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w_en, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [63:0] wd0, input logic [63:0] wd1,
                         input logic a_en, input logic [4:0] a_addr, input logic fl,
                         input logic [1:0] r_en, input logic [4:0] ra0, input logic [4:0] ra1);
        wen        = w_en;
        waddr      = {wa1, wa0};
        wdata      = {wd1, wd0};
        alloc_en   = a_en;
        alloc_addr = a_addr;
        flush      = fl;
        ren        = r_en;
        raddr      = {ra1, ra0};
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    endtask

    initial begin
        //             wen    wa0    wa1    wd0       wd1       aen   aaddr  ren    ra0    ra1    rd0       rd1       rrdy   stall busy
        vecs[0]  = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b1, 5'd7,  2'b11, 5'd7,  5'd3,  64'h0,    64'hBB,   2'b11, 1'b0, 32'h0};
        vecs[1]  = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b1, 5'd7,  2'b01, 5'd7,  5'd0,  64'h0,    64'h0,    2'b10, 1'b0, 32'h80};
        vecs[2]  = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b1, 5'd7,  2'b01, 5'd7,  5'd0,  64'h0,    64'h0,    2'b10, 1'b0, 32'h80};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b1, 5'd7,  2'b01, 5'd7,  5'd0,  64'h0,    64'h0,    2'b10, 1'b1, 32'h80};
        vecs[4]  = '{2'b11, 5'd7,  5'd7,  64'h11,   64'h22,   1'b0, 5'd0,  2'b01, 5'd7,  5'd0,  64'h22,   64'h0,    2'b10, 1'b0, 32'h80};
        vecs[5]  = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b0, 5'd0,  2'b01, 5'd7,  5'd0,  64'h22,   64'h0,    2'b10, 1'b0, 32'h80};
        vecs[6]  = '{2'b01, 5'd7,  5'd0,  64'h33,   64'h0,    1'b0, 5'd0,  2'b01, 5'd7,  5'd0,  64'h33,   64'h0,    2'b11, 1'b0, 32'h80};
        vecs[7]  = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b0, 5'd0,  2'b11, 5'd7,  5'd3,  64'h33,   64'hBB,   2'b11, 1'b0, 32'h0};
        vecs[8]  = '{2'b01, 5'd0,  5'd0,  64'hFF,   64'h0,    1'b1, 5'd0,  2'b11, 5'd0,  5'd7,  64'h0,    64'h33,   2'b11, 1'b0, 32'h0};
        vecs[9]  = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b1, 5'd0,  2'b01, 5'd0,  5'd0,  64'h0,    64'h0,    2'b11, 1'b0, 32'h0};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b1, 5'd2,  2'b10, 5'd0,  5'd2,  64'h0,    64'h0,    2'b11, 1'b0, 32'h0};
        vecs[11] = '{2'b10, 5'd0,  5'd2,  64'h0,    64'h55,   1'b1, 5'd2,  2'b10, 5'd0,  5'd2,  64'h0,    64'h55,   2'b11, 1'b0, 32'h4};
        vecs[12] = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b0, 5'd0,  2'b10, 5'd0,  5'd2,  64'h0,    64'h55,   2'b01, 1'b0, 32'h4};
        vecs[13] = '{2'b01, 5'd2,  5'd0,  64'h66,   64'h0,    1'b0, 5'd0,  2'b10, 5'd0,  5'd2,  64'h0,    64'h66,   2'b11, 1'b0, 32'h4};
        vecs[14] = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b0, 5'd0,  2'b00, 5'd2,  5'd7,  64'h0,    64'h0,    2'b11, 1'b0, 32'h0};
        vecs[15] = '{2'b01, 5'd9,  5'd0,  64'h77,   64'h0,    1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    2'b11, 1'b0, 32'h0};
        vecs[16] = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    1'b0, 5'd0,  2'b01, 5'd9,  5'd0,  64'h77,   64'h0,    2'b11, 1'b0, 32'h0};

        // Power-on reset
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd5, 5'd0);
        #3;
        check("reset busy_vec", 128'(busy), 128'h0);
        check("reset alloc_stall", 128'(stall), 128'h0);
        check("reset read x5", rdata[63:0], 128'h0);

        // Reset clears a written register; writes and allocs during reset are ignored
        step();
        drive(2'b01, 5'd5, 5'd0, 64'h1234, 64'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
        step();
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd5, 5'd0);
        #3;
        check("x5 written", rdata[63:0], 128'h1234);
        step();
        rst_n = 1'b0;
        drive(2'b01, 5'd5, 5'd0, 64'h9999, 64'd0, 1'b1, 5'd5, 1'b0, 2'b00, 5'd0, 5'd0);
        step();
        rst_n = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd5, 5'd0);
        #3;
        check("x5 after reset", rdata[63:0], 128'h0);
        check("busy after reset", 128'(busy), 128'h0);

        // Same-cycle dual write to x3: youngest port wins, bypass vs array-only read
        step();
        drive(2'b11, 5'd3, 5'd3, 64'hAA, 64'hBB, 1'b0, 5'd0, 1'b0, 2'b01, 5'd3, 5'd0);
        #3;
        check("bypass read x3", rdata[63:0], 128'hBB);
        check("no-bypass read x3", rdata_nb[63:0], 128'h0);
        check("no-bypass rready", 128'(rready_nb), 128'h3);
        check("no-bypass stall", 128'(stall_nb), 128'h0);
        check("no-bypass busy", 128'(busy_nb), 128'h0);
        step();
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd3, 5'd0);
        #3;
        check("array x3", rdata[63:0], 128'hBB);
        check("no-bypass array x3", rdata_nb[63:0], 128'hBB);

        // Vector table: scoreboard saturation, writebacks, x0, alloc+write, ren=0, stray write
        for (int i = 0; i < NVEC; i++) begin
            step();
            drive(vecs[i].wen, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
                  vecs[i].alloc_en, vecs[i].alloc_addr, 1'b0,
                  vecs[i].ren, vecs[i].ra0, vecs[i].ra1);
            #3;
            check($sformatf("v%0d rdata0", i), rdata[63:0], 128'(vecs[i].rd0));
            check($sformatf("v%0d rdata1", i), rdata[127:64], 128'(vecs[i].rd1));
            check($sformatf("v%0d rready", i), 128'(rready), 128'(vecs[i].rready));
            check($sformatf("v%0d alloc_stall", i), 128'(stall), 128'(vecs[i].stall));
            check($sformatf("v%0d busy_vec", i), 128'(busy), 128'(vecs[i].busy));
        end

        // Flush: x4 at 2, x9 at 1, flush alongside alloc x4 and a write to x9
        step();
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b1, 5'd4, 1'b0, 2'b00, 5'd0, 5'd0);
        step();
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b1, 5'd4, 1'b0, 2'b00, 5'd0, 5'd0);
        step();
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b1, 5'd9, 1'b0, 2'b00, 5'd0, 5'd0);
        step();
        drive(2'b01, 5'd9, 5'd0, 64'hABC, 64'd0, 1'b1, 5'd4, 1'b1, 2'b01, 5'd4, 5'd0);
        #3;
        check("pre-flush busy", 128'(busy), 128'h210);
        check("pre-flush rready x4", 128'(rready), 128'h2);
        step();
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd4, 5'd9);
        #3;
        check("post-flush busy", 128'(busy), 128'h0);
        check("post-flush rready", 128'(rready), 128'h3);
        check("post-flush x9 data", rdata[127:64], 128'hABC);

        step();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
